// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forward selects,
// MDU sequencer state encoding, default MDU latencies and a register-match helper.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam int MUL_LAT_DEF = 4;
    localparam int DIV_LAT_DEF = 32;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_BUSY = 2'b01,
        MDU_WB   = 2'b10
    } mdu_state_e;

    // $zero is hardwired, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-unit signal bundle. The pipeline (master) drives stage
// register/control info; the hazard unit (slave) returns stall, flush, forward and MDU status.
interface pipe_hazard_ctrl_if;
    import pipe_hazard_ctrl_pkg::*;

    logic [4:0] rsD, rtD, rsE, rtE;
    logic [4:0] writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW;
    logic       memtoregE, memtoregM;
    logic       branchD;
    logic       mdu_startD, mdu_readD;
    logic       mdu_startE, mdu_divE;

    logic       stallF, stallD, flushE;
    logic       forwardAD, forwardBD;
    logic [1:0] forwardAE, forwardBE;
    logic       mdu_busy, mdu_we;
    mdu_state_e mdu_state;

    // Outputs are purely level signals with no handshake: the pipeline applies
    // stall/flush/forward in the same cycle they are presented.
    modport master (
        output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
        output regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
        output branchD, mdu_startD, mdu_readD, mdu_startE, mdu_divE,
        input  stallF, stallD, flushE, forwardAD, forwardBD,
        input  forwardAE, forwardBE, mdu_busy, mdu_we, mdu_state
    );

    modport slave (
        input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
        input  regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
        input  branchD, mdu_startD, mdu_readD, mdu_startE, mdu_divE,
        output stallF, stallD, flushE, forwardAD, forwardBD,
        output forwardAE, forwardBE, mdu_busy, mdu_we, mdu_state
    );

endinterface

// File: rtl/pipe_hazard_ctrl_mdu_seq.sv
// Multiply/divide occupancy sequencer: IDLE/BUSY/WB FSM with a 5-bit down-counter
// that strobes the HI/LO write LAT-1 cycles after the op enters execute.
module mdu_seq
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_div,
    output logic       o_busy,
    output logic       o_we,
    output mdu_state_e o_state
);

    localparam logic [4:0] MUL_LOAD = 5'(MUL_LAT - 2);
    localparam logic [4:0] DIV_LOAD = 5'(DIV_LAT - 2);

    mdu_state_e r_state, w_state_next;
    logic [4:0] r_cnt, w_cnt_next;
    logic [4:0] w_load;

    assign w_load = i_div ? DIV_LOAD : MUL_LOAD;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MDU_IDLE;
            r_cnt   <= 5'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // cnt holds the BUSY cycles still to run; a zero load (LAT=2) goes straight to WB.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            MDU_IDLE, MDU_WB: begin
                if (i_start) begin
                    w_cnt_next   = w_load;
                    w_state_next = (w_load == 5'd0) ? MDU_WB : MDU_BUSY;
                end else begin
                    w_state_next = MDU_IDLE;
                end
            end
            MDU_BUSY: begin
                w_cnt_next = r_cnt - 5'd1;
                if (r_cnt <= 5'd1) begin
                    w_cnt_next   = 5'd0;
                    w_state_next = MDU_WB;
                end
            end
            default: begin
                w_state_next = MDU_IDLE;
                w_cnt_next   = 5'd0;
            end
        endcase
    end

    assign o_busy  = (r_state != MDU_IDLE);
    assign o_we    = (r_state == MDU_WB) && !rst;
    assign o_state = r_state;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use/branch/MDU stalls and
// M/W forwarding. Define HAZ_BRANCH_FWD_EN to enable M-stage forwarding into decode.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input logic              clk,
    input logic              rst,
    pipe_hazard_ctrl_if.slave hz
);

    mdu_state_e w_mdu_state;
    logic       w_mdu_busy, w_mdu_we;
    logic       w_match_e, w_match_m, w_brsrc_m;
    logic       w_lwstall, w_brstall, w_mdustall, w_stall;
    logic       w_fwd_ad, w_fwd_bd;

    mdu_seq #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_mdu_seq (
        .clk     (clk),
        .rst     (rst),
        .i_start (hz.mdu_startE),
        .i_div   (hz.mdu_divE),
        .o_busy  (w_mdu_busy),
        .o_we    (w_mdu_we),
        .o_state (w_mdu_state)
    );

    assign w_match_e = reg_match(hz.writeregE, hz.rsD) || reg_match(hz.writeregE, hz.rtD);
    assign w_match_m = reg_match(hz.writeregM, hz.rsD) || reg_match(hz.writeregM, hz.rtD);

`ifdef HAZ_BRANCH_FWD_EN
    // ALU results in M are forwarded to decode; only a load in M must wait.
    assign w_brsrc_m = hz.memtoregM;
    assign w_fwd_ad  = hz.regwriteM && reg_match(hz.writeregM, hz.rsD);
    assign w_fwd_bd  = hz.regwriteM && reg_match(hz.writeregM, hz.rtD);
`else
    logic w_unused_memtoregM;
    assign w_unused_memtoregM = hz.memtoregM;
    assign w_brsrc_m = hz.regwriteM;
    assign w_fwd_ad  = 1'b0;
    assign w_fwd_bd  = 1'b0;
`endif

    assign w_lwstall  = hz.memtoregE && w_match_e;
    assign w_brstall  = hz.branchD && ((hz.regwriteE && w_match_e) || (w_brsrc_m && w_match_m));
    assign w_mdustall = (hz.mdu_readD || hz.mdu_startD) &&
                        ((w_mdu_state == MDU_BUSY) || ((w_mdu_state == MDU_IDLE) && hz.mdu_startE));
    assign w_stall    = w_lwstall || w_brstall || w_mdustall;

    always_comb begin
        hz.stallF    = 1'b0;
        hz.stallD    = 1'b0;
        hz.flushE    = 1'b1;
        hz.forwardAD = 1'b0;
        hz.forwardBD = 1'b0;
        hz.forwardAE = FWD_RF;
        hz.forwardBE = FWD_RF;
        if (!rst) begin
            hz.stallF    = w_stall;
            hz.stallD    = w_stall;
            hz.flushE    = w_stall;
            hz.forwardAD = w_fwd_ad;
            hz.forwardBD = w_fwd_bd;
            if (hz.regwriteM && reg_match(hz.writeregM, hz.rsE))
                hz.forwardAE = FWD_M;
            else if (hz.regwriteW && reg_match(hz.writeregW, hz.rsE))
                hz.forwardAE = FWD_W;
            if (hz.regwriteM && reg_match(hz.writeregM, hz.rtE))
                hz.forwardBE = FWD_M;
            else if (hz.regwriteW && reg_match(hz.writeregW, hz.rtE))
                hz.forwardBE = FWD_W;
        end
    end

    assign hz.mdu_busy  = w_mdu_busy;
    assign hz.mdu_we    = w_mdu_we;
    assign hz.mdu_state = w_mdu_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding, load-use, branch and MDU
// sequencing, with expected output vectors queued per cycle and checked on the falling edge.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

`ifdef HAZ_BRANCH_FWD_EN
    localparam bit BR_FWD = 1'b1;
`else
    localparam bit BR_FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hz();

    pipe_hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    logic [10:0] exp_q[$];
    string       tag_q[$];
    int          vectors     = 0;
    int          miscompares = 0;

    logic [10:0] got;
    assign got = {hz.stallF, hz.stallD, hz.flushE, hz.forwardAD, hz.forwardBD,
                  hz.forwardAE, hz.forwardBE, hz.mdu_busy, hz.mdu_we};

    function automatic logic [10:0] pk(input bit st, input bit fl, input bit ad, input bit bd,
                                       input logic [1:0] ae, input logic [1:0] be,
                                       input bit busy, input bit we);
        return {st, st, fl, ad, bd, ae, be, busy, we};
    endfunction

    task automatic clear_inputs();
        hz.rsD = 5'd0; hz.rtD = 5'd0; hz.rsE = 5'd0; hz.rtE = 5'd0;
        hz.writeregE = 5'd0; hz.writeregM = 5'd0; hz.writeregW = 5'd0;
        hz.regwriteE = 1'b0; hz.regwriteM = 1'b0; hz.regwriteW = 1'b0;
        hz.memtoregE = 1'b0; hz.memtoregM = 1'b0; hz.branchD = 1'b0;
        hz.mdu_startD = 1'b0; hz.mdu_readD = 1'b0;
        hz.mdu_startE = 1'b0; hz.mdu_divE = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out();
        logic [10:0] e;
        string       t;
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        vectors++;
        assert (got === e) else begin
            miscompares++;
            $error("FAIL %s observed={sF,sD,fE,fAD,fBD,fAE,fBE,busy,we}=%b expected=%b", t, got, e);
        end
    endtask

    // Inputs for the current cycle are already applied; check, then advance one cycle.
    task automatic step(input string tag, input logic [10:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        check_out();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        hz.memtoregE = 1'b1; hz.writeregE = 5'd5; hz.rsD = 5'd5;
        hz.regwriteM = 1'b1; hz.writeregM = 5'd7; hz.rsE = 5'd7;
        tick();
        step("reset_outputs", pk(0, 1, 0, 0, FWD_RF, FWD_RF, 0, 0));

        rst = 1'b0;
        clear_inputs();
        step("idle_after_reset", pk(0, 0, 0, 0, FWD_RF, FWD_RF, 0, 0));

        hz.memtoregE = 1'b1; hz.writeregE = 5'd5; hz.rsD = 5'd5;
        step("load_use_rs", pk(1, 1, 0, 0, FWD_RF, FWD_RF, 0, 0));
        hz.memtoregE = 1'b0;
        step("load_use_cleared", pk(0, 0, 0, 0, FWD_RF, FWD_RF, 0, 0));
        clear_inputs();
        hz.memtoregE = 1'b1; hz.writeregE = 5'd0;
        step("load_use_r0", pk(0, 0, 0, 0, FWD_RF, FWD_RF, 0, 0));
        hz.writeregE = 5'd12; hz.rtD = 5'd12;
        step("load_use_rt", pk(1, 1, 0, 0, FWD_RF, FWD_RF, 0, 0));

        clear_inputs();
        hz.regwriteM = 1'b1; hz.regwriteW = 1'b1;
        hz.writeregM = 5'd7; hz.writeregW = 5'd7; hz.rsE = 5'd7;
        step("fwd_ae_m_prio", pk(0, 0, 0, 0, FWD_M, FWD_RF, 0, 0));
        hz.writeregM = 5'd0;
        step("fwd_ae_w", pk(0, 0, 0, 0, FWD_W, FWD_RF, 0, 0));
        hz.rsE = 5'd0;
        step("fwd_ae_r0", pk(0, 0, 0, 0, FWD_RF, FWD_RF, 0, 0));
        hz.writeregM = 5'd4; hz.writeregW = 5'd9; hz.rtE = 5'd9;
        step("fwd_be_w", pk(0, 0, 0, 0, FWD_RF, FWD_W, 0, 0));
        hz.rtE = 5'd4; hz.rsE = 5'd9;
        step("fwd_be_m_ae_w", pk(0, 0, 0, 0, FWD_W, FWD_M, 0, 0));

        clear_inputs();
        hz.branchD = 1'b1; hz.regwriteE = 1'b1; hz.writeregE = 5'd3; hz.rtD = 5'd3;
        step("branch_dep_e", pk(1, 1, 0, 0, FWD_RF, FWD_RF, 0, 0));
        clear_inputs();
        hz.branchD = 1'b1; hz.regwriteM = 1'b1; hz.writeregM = 5'd3; hz.rsD = 5'd3;
        step("branch_alu_m", pk(!BR_FWD, !BR_FWD, BR_FWD, 0, FWD_RF, FWD_RF, 0, 0));
        hz.memtoregM = 1'b1;
        step("branch_load_m", pk(1, 1, BR_FWD, 0, FWD_RF, FWD_RF, 0, 0));
        clear_inputs();
        hz.regwriteM = 1'b1; hz.writeregM = 5'd6; hz.rtD = 5'd6;
        step("fwd_bd_no_branch", pk(0, 0, 0, BR_FWD, FWD_RF, FWD_RF, 0, 0));

        clear_inputs();
        hz.mdu_startE = 1'b1; hz.mdu_divE = 1'b0; hz.mdu_readD = 1'b1;
        step("mul_c0", pk(1, 1, 0, 0, FWD_RF, FWD_RF, 0, 0));
        hz.mdu_startE = 1'b0;
        step("mul_c1", pk(1, 1, 0, 0, FWD_RF, FWD_RF, 1, 0));
        step("mul_c2", pk(1, 1, 0, 0, FWD_RF, FWD_RF, 1, 0));
        step("mul_c3", pk(0, 0, 0, 0, FWD_RF, FWD_RF, 1, 1));
        hz.mdu_readD = 1'b0;
        step("mul_c4", pk(0, 0, 0, 0, FWD_RF, FWD_RF, 0, 0));

        clear_inputs();
        hz.mdu_startE = 1'b1; hz.mdu_divE = 1'b1;
        step("div_c0", pk(0, 0, 0, 0, FWD_RF, FWD_RF, 0, 0));
        clear_inputs();
        for (int c = 1; c <= 30; c++)
            step($sformatf("div_c%0d", c), pk(0, 0, 0, 0, FWD_RF, FWD_RF, 1, 0));
        hz.mdu_startE = 1'b1; hz.mdu_divE = 1'b1; hz.mdu_startD = 1'b1;
        step("div_c31_wb_restart", pk(0, 0, 0, 0, FWD_RF, FWD_RF, 1, 1));
        clear_inputs();
        for (int c = 32; c <= 61; c++)
            step($sformatf("div2_c%0d", c), pk(0, 0, 0, 0, FWD_RF, FWD_RF, 1, 0));
        step("div2_c62_wb", pk(0, 0, 0, 0, FWD_RF, FWD_RF, 1, 1));
        step("div2_c63_idle", pk(0, 0, 0, 0, FWD_RF, FWD_RF, 0, 0));

        hz.mdu_startE = 1'b1; hz.mdu_divE = 1'b1;
        step("rdiv_c0", pk(0, 0, 0, 0, FWD_RF, FWD_RF, 0, 0));
        clear_inputs();
        for (int c = 1; c <= 9; c++)
            step($sformatf("rdiv_c%0d", c), pk(0, 0, 0, 0, FWD_RF, FWD_RF, 1, 0));
        rst = 1'b1;
        step("rdiv_c10_rst", pk(0, 1, 0, 0, FWD_RF, FWD_RF, 1, 0));
        rst = 1'b0;
        for (int c = 11; c <= 40; c++)
            step($sformatf("rdiv_c%0d_abandoned", c), pk(0, 0, 0, 0, FWD_RF, FWD_RF, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
